// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the parametrised UART core
package uart_pkg;
  localparam int MAX_DATA_BITS = 9;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic perr;
    logic ferr;
  } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead synchronous FIFO; a push while full succeeds only alongside a pop
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic wr_en, rd_en;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
    end else begin
      if (wr_en) wr <= wr == AW'(DEPTH-1) ? '0 : wr + 1'b1;
      if (rd_en) rd <= rd == AW'(DEPTH-1) ? '0 : rd + 1'b1;
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with runtime baud divider, oversampled RX and RX FIFO
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [15:0]                        baud_div,
  input  logic                               tx_enable,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [DATA_BITS-1:0]               tx_data,
  output logic                               tx_out,
  output logic                               tx_empty,
  input  logic                               rx_enable,
  input  logic                               rx_in,
  input  logic                               loopback,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_parity_err,
  output logic                               rx_frame_err,
  output logic                               rx_overrun,
  input  logic                               clr_overrun,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0] rx_level
);
  localparam int CW = $clog2(2*OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam parity_e PAR = parity_e'(PARITY);
  localparam bit ODD = PAR == PAR_ODD;
  logic [15:0] tick_cnt;
  logic tick;
  assign tick = tick_cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tick_cnt <= '0;
    else tick_cnt <= tick ? baud_div : tick_cnt - 16'd1;
  tx_state_e tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [IW-1:0] tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic tx_par, tx_end, tx_acc;
  assign tx_ready = tx_enable && tx_state == TX_IDLE;
  assign tx_acc = tx_valid && tx_ready;
  assign tx_empty = tx_state == TX_IDLE;
  assign tx_end = tick && tx_cnt == (tx_state == TX_STOP ? CW'(STOP_BITS*OVERSAMPLE-1) : CW'(OVERSAMPLE-1));
  assign tx_out = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : tx_state == TX_PARITY ? tx_par : 1'b1;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_acc) tx_next = TX_START;
      TX_START:  if (tx_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_end && tx_idx == IW'(DATA_BITS-1)) tx_next = PAR == PAR_NONE ? TX_STOP : TX_PARITY;
      TX_PARITY: if (tx_end) tx_next = TX_STOP;
      TX_STOP:   if (tx_end) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_acc) begin
        tx_sh <= tx_data;
        tx_par <= ^tx_data ^ ODD;
        tx_cnt <= '0;
        tx_idx <= '0;
      end else if (tick && !tx_empty) begin
        tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
        if (tx_end && tx_state == TX_DATA) begin
          tx_sh <= tx_sh >> 1;
          tx_idx <= tx_idx + 1'b1;
        end
      end
    end
  rx_state_e rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [IW-1:0] rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic s1, rx_bit, rx_pbit, rx_samp, push, pop, full, empty, perr, overrun;
  // START waits half a bit to land on the bit centre; later bits are a full bit apart
  assign rx_samp = tick && rx_cnt == (rx_state == RX_START ? CW'(OVERSAMPLE/2-1) : CW'(OVERSAMPLE-1));
  assign push = rx_enable && rx_state == RX_STOP && rx_samp;
  assign pop = rx_valid && rx_ready;
  assign perr = PAR != PAR_NONE && (rx_pbit != (^rx_sh ^ ODD));
  assign rx_valid = !empty;
  assign rx_overrun = overrun;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (tick && !rx_bit) rx_next = RX_START;
      RX_START:  if (rx_samp) rx_next = rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_samp && rx_idx == IW'(DATA_BITS-1)) rx_next = PAR == PAR_NONE ? RX_STOP : RX_PARITY;
      RX_PARITY: if (rx_samp) rx_next = RX_STOP;
      RX_STOP:   if (rx_samp) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
    if (!rx_enable) rx_next = RX_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b1;
      rx_bit <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_pbit <= 1'b0;
      overrun <= 1'b0;
    end else begin
      {rx_bit, s1} <= {s1, loopback ? tx_out : rx_in};
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= '0;
        rx_idx <= '0;
      end else if (tick) rx_cnt <= rx_samp ? '0 : rx_cnt + 1'b1;
      if (rx_samp && rx_state == RX_DATA) begin
        rx_sh <= {rx_bit, rx_sh[DATA_BITS-1:1]};
        rx_idx <= rx_idx + 1'b1;
      end
      if (rx_samp && rx_state == RX_PARITY) rx_pbit <= rx_bit;
      overrun <= (push && full && !pop) || (overrun && !clr_overrun);
    end
  uart_rx_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din({rx_sh, perr, !rx_bit}),
    .dout({rx_data, rx_parity_err, rx_frame_err}),
    .full(full),
    .empty(empty),
    .level(rx_level)
  );
endmodule
